accel_stream_core: RTL

ACCEL_STREAM_CORE -- requirements
Module: accel_stream_core

---
 rtl/accel_stream_core.sv | 132 +++++++++++++
 1 files changed

// File: rtl/accel_stream_core.sv
// rtl/accel_stream_core.sv - task-framed streaming add-constant core with start/done handshake
//
// Accepts TASK_LEN beats per task on s_axis, adds ADD_CONST to each, and
// emits them on m_axis through a single output register, with tlast on the
// final beat of the task.
//
// Ports:
//   ACLK, ARESET          clock (rising edge), asynchronous active-high reset
//   ACLK_EN               clock enable; low freezes every register
//   ap_start / ap_ready   task request and its same-cycle acceptance
//   ap_done / ap_idle     one-cycle completion pulse / no task in progress
//   s_axis_*              input stream (tlast is checked, never used for framing)
//   m_axis_*              output stream, tlast marks the last beat of the task
//   tlast_err             one-cycle pulse when input tlast disagrees with beat count
module accel_stream_core #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    TASK_LEN   = 16,
    parameter logic [DATA_WIDTH-1:0] ADD_CONST  = '0
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  ACLK_EN,
    input  logic                  ap_start,
    output logic                  ap_ready,
    output logic                  ap_done,
    output logic                  ap_idle,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  tlast_err
);

    localparam logic [15:0] TASK_LEN_C = 16'(TASK_LEN);
    localparam logic [15:0] LAST_IDX   = 16'(TASK_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [15:0]           in_count_q, in_count_d;
    logic                  m_tvalid_q, m_tvalid_d;
    logic                  m_tlast_q, m_tlast_d;
    logic [DATA_WIDTH-1:0] m_tdata_q, m_tdata_d;

    logic s_hs;
    logic m_hs;
    logic beat_is_last;

    assign beat_is_last = (in_count_q == LAST_IDX);

    // Both handshakes are qualified by ACLK_EN so a frozen core never
    // consumes or retires a beat, even though tvalid is held.
    assign s_axis_tready = ACLK_EN && (state_q == ST_RUN) && (in_count_q < TASK_LEN_C)
                           && (!m_tvalid_q || m_axis_tready);
    assign s_hs          = s_axis_tvalid && s_axis_tready;
    assign m_hs          = ACLK_EN && m_tvalid_q && m_axis_tready;

    // ARESET is included so a start held through reset is not reported as accepted.
    assign ap_ready  = !ARESET && ACLK_EN && (state_q == ST_IDLE) && ap_start;
    assign ap_idle   = (state_q == ST_IDLE);
    assign ap_done   = ACLK_EN && (state_q == ST_DONE);
    assign tlast_err = s_hs && (s_axis_tlast != beat_is_last);

    assign m_axis_tdata  = m_tdata_q;
    assign m_axis_tvalid = m_tvalid_q;
    assign m_axis_tlast  = m_tlast_q;

    always_comb begin
        state_d    = state_q;
        in_count_d = in_count_q;
        m_tvalid_d = m_tvalid_q;
        m_tlast_d  = m_tlast_q;
        m_tdata_d  = m_tdata_q;
        case (state_q)
            ST_IDLE: begin
                if (ap_start) begin
                    state_d    = ST_RUN;
                    in_count_d = '0;
                end
            end
            ST_RUN: begin
                // A new beat overwrites the register whether or not the old
                // one drains this cycle; tready already guarantees it has.
                if (s_hs) begin
                    m_tdata_d  = s_axis_tdata + ADD_CONST;
                    m_tvalid_d = 1'b1;
                    m_tlast_d  = beat_is_last;
                    in_count_d = in_count_q + 16'd1;
                end else if (m_hs) begin
                    m_tvalid_d = 1'b0;
                    m_tlast_d  = 1'b0;
                end
                // in_count is saturated when the last beat drains, so no
                // input handshake can coincide with this transition.
                if (m_hs && m_tlast_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q    <= ST_IDLE;
            in_count_q <= '0;
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
            m_tdata_q  <= '0;
        end else if (ACLK_EN) begin
            state_q    <= state_d;
            in_count_q <= in_count_d;
            m_tvalid_q <= m_tvalid_d;
            m_tlast_q  <= m_tlast_d;
            m_tdata_q  <= m_tdata_d;
        end
    end

endmodule
